shift_arb: RTL
==============

SHIFT_ARB -- requirements
Module: shift_arb

Interface
REQ-001 SHALL have parameter W, default 8, giving the data width in bits; W SHALL be a power of two and at least 2.
REQ-002 SHALL have derived parameter SW = $clog2(W), giving the shift-amount width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have ports req0_valid and req1_valid, input, 1 bit each: requester 0/1 presents an operation.
REQ-006 SHALL have ports req0_ready and req1_ready, output, 1 bit each: the operation is accepted this cycle.
REQ-007 SHALL have ports req0_din and req1_din, input, W bits each: operand.
REQ-008 SHALL have ports req0_shamt and req1_shamt, input, SW bits each: shift amount.
REQ-009 SHALL have ports req0_lr and req1_lr, input, 1 bit each: 1 = left shift, 0 = right shift.
REQ-010 SHALL have ports req0_al and req1_al, input, 1 bit each: 1 = arithmetic, 0 = logical.
REQ-011 SHALL have port out_valid, output, 1 bit: a result is held.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-013 SHALL have port out_dout, output, W bits: the shifted result.
REQ-014 SHALL have port out_id, output, 1 bit: the index of the requester that owns the result.

Function
REQ-015 SHALL contain a two-state FSM:
- EMPTY -> FULL on accept.
- FULL -> EMPTY on out_ready with no new accept.
- FULL -> FULL on simultaneous drain and accept.
REQ-016 SHALL set can_accept = (state == EMPTY) or out_ready.
REQ-017 SHALL assert at most one reqN_ready per cycle; a requester SHALL be granted only if its valid is high and can_accept is true.
REQ-018 SHALL arbitrate round-robin:
- When both requesters are valid, grant the one not granted last.
- When one requester is valid, grant it regardless of the pointer.
- The pointer SHALL update only on an accept.
REQ-019 SHALL compute the result combinationally from the granted request and register it; out_valid SHALL rise in the cycle after the accept (latency 1).
REQ-020 SHALL perform the following operations:
- Right logical: zero fill.
- Right arithmetic: fill with din[W-1].
- Left: zero fill; al is ignored for left unless REQ-026 applies.
- shamt = 0: dout = din.
REQ-021 SHALL keep out_dout and out_id stable while out_valid is high and out_ready is low.
REQ-022 SHALL let requesters hold valid without dropping it; a non-granted valid request SHALL stay pending and SHALL NOT be lost.
REQ-023 SHALL sustain one accept per cycle when out_ready is held high (full throughput).

Reset
REQ-024 SHALL, while rst is high, force:
- out_valid = 0, out_dout = 0, out_id = 0.
- The round-robin pointer to "last = 1", so requester 0 wins the first tie.
- state = EMPTY and both reqN_ready = 0.
REQ-025 SHALL discard any held result when reset is asserted mid-operation; the first accept after reset release SHALL behave as in REQ-018.

Configuration
REQ-026 SHALL, with SHIFT_ARB_ROTATE_EN defined, perform rotate-left for lr = 1 and al = 1; without the macro, lr = 1 and al = 1 SHALL perform a logical left shift.

Structure
REQ-027 SHALL place the FSM state enum, the requester ID constants (ID0, ID1) and the op-decode typedef {lr, al} in package shift_arb_pkg.
REQ-028 SHALL instantiate one combinational sub-module, barrel_shifter (din, shamt, lr, al -> dout), with the rotate option passed through by macro.

Verification
REQ-029 SHALL cover reset default: hold rst, then release -> out_valid = 0, out_dout = 0x00; first tie is granted to requester 0.
REQ-030 SHALL cover single requests:
- req0 {din = 0xB4, shamt = 3, lr = 0, al = 1} -> next cycle out_dout = 0xF6, out_id = 0.
- {lr = 0, al = 0} -> out_dout = 0x16.
REQ-031 SHALL cover a left shift and the rotate option:
- req1 {din = 0x81, shamt = 1, lr = 1, al = 1} -> out_dout = 0x02 without the macro.
- The same request -> out_dout = 0x03 with SHIFT_ARB_ROTATE_EN.
REQ-032 SHALL cover contention: both requesters valid for 4 cycles with out_ready = 1 -> grants 0,1,0,1; out_id follows the same sequence one cycle later.
REQ-033 SHALL cover backpressure: out_ready = 0 for 3 cycles while FULL -> both reqN_ready = 0 and out_dout stable; raising out_ready with req0 valid -> drain and accept in the same cycle, and out_valid stays high.
REQ-034 SHALL cover reset while FULL: assert rst with out_valid = 1 -> out_valid = 0 immediately; after release the pending request is accepted within 1 cycle.

Source files
------------

// File: rtl/shift_arb_pkg.sv
// rtl/shift_arb_pkg.sv - shared types and constants for the shift arbiter
package shift_arb_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic ID0 = 1'b0;
    localparam logic ID1 = 1'b1;

    typedef struct packed {
        logic lr;
        logic al;
    } op_t;

endpackage

// File: rtl/shift_arb_barrel_shifter.sv
// rtl/shift_arb_barrel_shifter.sv - combinational barrel shifter
// SHIFT_ARB_ROTATE_EN turns the left-arithmetic encoding into rotate-left.
module barrel_shifter
    import shift_arb_pkg::*;
#(
    parameter int W  = 8,
    parameter int SW = $clog2(W)
) (
    input  logic [W-1:0]  din,
    input  logic [SW-1:0] shamt,
    input  logic          lr,
    input  logic          al,
    output logic [W-1:0]  dout
);

    op_t op;
    assign op = '{lr: lr, al: al};

`ifdef SHIFT_ARB_ROTATE_EN
    logic [2*W-1:0] dbl;
    // Shifting a doubled copy leaves the rotated word in the upper half.
    assign dbl = {din, din} << shamt;
`endif

    always_comb begin
        dout = din >> shamt;
        if (op.lr) begin
`ifdef SHIFT_ARB_ROTATE_EN
            dout = op.al ? dbl[2*W-1:W] : (din << shamt);
`else
            dout = din << shamt;
`endif
        end else if (op.al) begin
            dout = $signed(din) >>> shamt;
        end
    end

endmodule

// File: rtl/shift_arb.sv
// rtl/shift_arb.sv - two-requester round-robin arbiter feeding a registered shifter
// SHIFT_ARB_ROTATE_EN enables rotate-left in the shifter.
module shift_arb
    import shift_arb_pkg::*;
#(
    parameter int  W  = 8,
    localparam int SW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [W-1:0]  req0_din,
    input  logic [SW-1:0] req0_shamt,
    input  logic          req0_lr,
    input  logic          req0_al,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [W-1:0]  req1_din,
    input  logic [SW-1:0] req1_shamt,
    input  logic          req1_lr,
    input  logic          req1_al,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_dout,
    output logic          out_id
);

    state_t        state, state_n;
    logic          last;
    logic          can_accept;
    logic          accept;
    logic          gnt_id;
    logic [W-1:0]  gnt_din;
    logic [SW-1:0] gnt_shamt;
    logic          gnt_lr;
    logic          gnt_al;
    logic [W-1:0]  shifted;

    always_comb begin
        can_accept = (state == EMPTY) || out_ready;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        // Requester 0 wins only when alone or when requester 1 went last.
        if (!rst && can_accept) begin
            if (req0_valid && (!req1_valid || last == ID1)) begin
                req0_ready = 1'b1;
            end else if (req1_valid) begin
                req1_ready = 1'b1;
            end
        end
        accept    = req0_ready | req1_ready;
        gnt_id    = req1_ready ? ID1 : ID0;
        gnt_din   = req1_ready ? req1_din   : req0_din;
        gnt_shamt = req1_ready ? req1_shamt : req0_shamt;
        gnt_lr    = req1_ready ? req1_lr    : req0_lr;
        gnt_al    = req1_ready ? req1_al    : req0_al;

        state_n = state;
        case (state)
            EMPTY:   if (accept) state_n = FULL;
            FULL:    if (out_ready && !accept) state_n = EMPTY;
            default: state_n = EMPTY;
        endcase
    end

    barrel_shifter #(.W(W), .SW(SW)) u_shifter (
        .din   (gnt_din),
        .shamt (gnt_shamt),
        .lr    (gnt_lr),
        .al    (gnt_al),
        .dout  (shifted)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last     <= ID1;
            out_dout <= '0;
            out_id   <= ID0;
        end else if (accept) begin
            last     <= gnt_id;
            out_dout <= shifted;
            out_id   <= gnt_id;
        end
    end

    assign out_valid = (state == FULL);

endmodule
